// File: rtl/tour_pkg.sv
// Shared types and constants for the tour command path: opcodes, headings,
// host response bytes and the tour FSM state encoding.
package tour_pkg;

  localparam logic [3:0] OP_MOVE         = 4'b0100;
  localparam logic [3:0] OP_MOVE_FANFARE = 4'b0101;
  localparam logic [3:0] OP_CALIBRATE    = 4'b0010;
  localparam logic [3:0] OP_TOUR_GO      = 4'b0110;

  localparam logic [7:0] HDG_N = 8'h00;
  localparam logic [7:0] HDG_W = 8'h3F;
  localparam logic [7:0] HDG_S = 8'h7F;
  localparam logic [7:0] HDG_E = 8'hBF;

  localparam logic [7:0] RESP_ACK = 8'hA5;
  localparam logic [7:0] RESP_POS = 8'h5A;

  typedef enum logic [2:0] {
    IDLE,
    VERT,
    VERT_WT,
    HORZ,
    HORZ_WT
  } tour_state_e;

endpackage

// File: rtl/tour_move_decode.sv
// One-hot knight move to vertical/horizontal command-processor MOVE commands.
// Build option TOUR_CMD_FANFARE_EN selects the fanfare opcode on the horizontal leg.
module tour_move_decode
  import tour_pkg::*;
(
  input  logic [7:0]  move,
  output logic [15:0] vert_cmd,
  output logic [15:0] horz_cmd
);

`ifdef TOUR_CMD_FANFARE_EN
  localparam logic [3:0] HORZ_OP = OP_MOVE_FANFARE;
`else
  localparam logic [3:0] HORZ_OP = OP_MOVE;
`endif

  logic [2:0] sel;
  logic       found;
  logic       x_pos, y_pos;
  logic [2:0] x_mag, y_mag;

  // Lowest set bit wins when the move byte is not strictly one-hot
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (move[i] && !found) begin
        sel   = i[2:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    x_pos = 1'b1;
    x_mag = 3'd1;
    y_pos = 1'b1;
    y_mag = 3'd2;
    case (sel)
      3'd0: begin x_pos = 1'b1; x_mag = 3'd1; y_pos = 1'b1; y_mag = 3'd2; end
      3'd1: begin x_pos = 1'b0; x_mag = 3'd1; y_pos = 1'b1; y_mag = 3'd2; end
      3'd2: begin x_pos = 1'b0; x_mag = 3'd2; y_pos = 1'b1; y_mag = 3'd1; end
      3'd3: begin x_pos = 1'b0; x_mag = 3'd2; y_pos = 1'b0; y_mag = 3'd1; end
      3'd4: begin x_pos = 1'b0; x_mag = 3'd1; y_pos = 1'b0; y_mag = 3'd2; end
      3'd5: begin x_pos = 1'b1; x_mag = 3'd1; y_pos = 1'b0; y_mag = 3'd2; end
      3'd6: begin x_pos = 1'b1; x_mag = 3'd2; y_pos = 1'b0; y_mag = 3'd1; end
      default: begin x_pos = 1'b1; x_mag = 3'd2; y_pos = 1'b1; y_mag = 3'd1; end
    endcase
  end

  assign vert_cmd = {OP_MOVE, (y_pos ? HDG_N : HDG_S), 1'b0, y_mag};
  assign horz_cmd = {HORZ_OP, (x_pos ? HDG_E : HDG_W), 1'b0, x_mag};

endmodule

// File: rtl/tour_cmd.sv
// Muxes host (UART) commands with self-generated knight-tour MOVE commands.
// Build option TOUR_CMD_FANFARE_EN (in tour_move_decode) enables fanfare moves.
module tour_cmd
  import tour_pkg::*;
#(
  parameter int unsigned NUM_MOVES = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_tour,
  input  logic [7:0]  move,
  output logic [4:0]  mv_indx,
  input  logic [15:0] cmd_UART,
  input  logic        cmd_rdy_UART,
  output logic        clr_cmd_rdy_UART,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  input  logic        send_resp,
  output logic [7:0]  resp
);

  localparam logic [4:0] LAST_IDX = 5'(NUM_MOVES - 1);

  tour_state_e state, nxt_state;
  logic [15:0] vert_cmd, horz_cmd;
  logic        last_move;
  logic        clr_indx, inc_indx;

  tour_move_decode u_decode (
    .move     (move),
    .vert_cmd (vert_cmd),
    .horz_cmd (horz_cmd)
  );

  assign last_move = (mv_indx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      mv_indx <= '0;
    end else begin
      state <= nxt_state;
      if (clr_indx)
        mv_indx <= '0;
      else if (inc_indx)
        mv_indx <= mv_indx + 5'd1;
    end
  end

  always_comb begin
    nxt_state        = state;
    clr_indx         = 1'b0;
    inc_indx         = 1'b0;
    cmd              = vert_cmd;
    cmd_rdy          = 1'b0;
    clr_cmd_rdy_UART = 1'b0;
    resp             = RESP_POS;
    case (state)
      IDLE: begin
        cmd              = cmd_UART;
        cmd_rdy          = cmd_rdy_UART;
        clr_cmd_rdy_UART = clr_cmd_rdy;
        resp             = RESP_ACK;
        if (start_tour) begin
          clr_indx  = 1'b1;
          nxt_state = VERT;
        end
      end
      // An empty move slot terminates the tour without issuing anything
      VERT: begin
        if (move == 8'h00) begin
          nxt_state = IDLE;
        end else begin
          cmd_rdy = 1'b1;
          if (clr_cmd_rdy)
            nxt_state = VERT_WT;
        end
      end
      VERT_WT: begin
        if (send_resp)
          nxt_state = HORZ;
      end
      HORZ: begin
        cmd     = horz_cmd;
        cmd_rdy = 1'b1;
        if (clr_cmd_rdy)
          nxt_state = HORZ_WT;
      end
      HORZ_WT: begin
        cmd = horz_cmd;
        if (last_move)
          resp = RESP_ACK;
        if (send_resp) begin
          if (last_move) begin
            nxt_state = IDLE;
          end else begin
            inc_indx  = 1'b1;
            nxt_state = VERT;
          end
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

endmodule

// File: doc/tour_cmd.md
Name: tour_cmd

Overview:
Sits directly upstream of the command processor. It multiplexes between host commands (UART path) and self-generated tour commands. During a tour it reads one-hot knight moves from the tour solver's move memory by index. Each move becomes two command-processor MOVE commands (vertical leg, then horizontal leg); the block handshakes each one and returns responses to the host.

Parameters:
NUM_MOVES, 24, number of knight moves in a full tour (5x5 board); last index is NUM_MOVES-1.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous active-low
start_tour  input  1  one-cycle pulse from tour solver: begin issuing moves at index 0
move  input  8  one-hot knight move at mv_indx (combinational read of solver memory)
mv_indx  output  5  index of move currently being issued
cmd_UART  input  16  command assembled by UART wrapper
cmd_rdy_UART  input  1  UART command valid
clr_cmd_rdy_UART  output  1  clears UART wrapper's cmd_rdy
cmd  output  16  command to command processor ([15:12] opcode, [11:4] heading, [2:0] squares)
cmd_rdy  output  1  cmd valid to command processor
clr_cmd_rdy  input  1  command processor consumed cmd
send_resp  input  1  command processor finished a command
resp  output  8  response byte sent back to host

Behaviour:
- Reset values, sync on clk edge with rst_n=0: state=IDLE, mv_indx=0, cmd_rdy=0, clr_cmd_rdy_UART=0, resp=8'hA5. Reset mid-tour aborts immediately with no pending command.
- Move encoding (bit: dx,dy):
  - 0: +1,+2; 1: -1,+2; 2: -2,+1; 3: -2,-1
  - 4: -1,-2; 5: +1,-2; 6: +2,-1; 7: +2,+1
- Move priority: lowest set bit wins if more than one bit is set.
- Headings [11:4]:
  - North (+y) 8'h00; West (-x) 8'h3F; South (-y) 8'h7F; East (+x) 8'hBF.
- Squares [2:0]: |dy| for the vertical leg, |dx| for the horizontal leg.
- Opcodes:
  - Vertical leg: 4'b0100 (MOVE).
  - Horizontal leg: 4'b0101 (MOVE with fanfare); see Optional Feature.
  - cmd[3] = 0.
- States: IDLE, VERT, VERT_WT, HORZ, HORZ_WT.
- IDLE:
  - Output mux selects UART: cmd=cmd_UART, cmd_rdy=cmd_rdy_UART, clr_cmd_rdy_UART=clr_cmd_rdy (combinational pass-through).
  - resp=8'hA5.
  - On start_tour: mv_indx<=0, go VERT. cmd_rdy is asserted the next cycle (1-cycle latency).
- VERT:
  - Mux selects internal cmd; cmd_rdy=1; clr_cmd_rdy_UART=0.
  - On clr_cmd_rdy: go VERT_WT, cmd_rdy drops the same cycle.
- VERT_WT:
  - cmd_rdy=0, resp=8'h5A.
  - On send_resp: go HORZ.
- HORZ: as VERT but with the horizontal command; on clr_cmd_rdy go HORZ_WT.
- HORZ_WT:
  - resp=8'h5A, except resp=8'hA5 when mv_indx==NUM_MOVES-1.
  - On send_resp: if mv_indx==NUM_MOVES-1 go IDLE (mv_indx held); else mv_indx<=mv_indx+1, go VERT.
- Boundary rules:
  - move==8'h00 sampled in VERT: tour terminated; go IDLE, no command issued.
  - start_tour outside IDLE is ignored.
  - send_resp in VERT/HORZ (before clr_cmd_rdy) is ignored.
  - cmd_rdy_UART during a tour is not forwarded and not cleared; it is served after return to IDLE.
  - clr_cmd_rdy and send_resp in the same cycle in VERT: take clr only; send_resp is lost, and the command processor never does this.
- mv_indx is stable from VERT entry through HORZ_WT, so move is read combinationally; no latch is needed.

Optional Feature:
TOUR_CMD_FANFARE_EN
- Defined: horizontal-leg opcode is 4'b0101, so the fanfare plays after each completed knight move.
- Undefined: both legs use 4'b0100.

Decomposition:
- Shared package tour_pkg: opcode localparams (MOVE, MOVE_FANFARE, CALIBRATE, TOUR_GO), heading localparams (HDG_N/W/S/E), response constants (RESP_ACK 8'hA5, RESP_POS 8'h5A), state enum typedef.
- Sub-module tour_move_decode: combinational 8-bit one-hot to {vert_cmd, horz_cmd}. Keeps the FSM file small and is unit-testable.

Test Plan:
- Idle pass-through: cmd_UART=16'h4023 with cmd_rdy_UART=1, pulse clr_cmd_rdy -> cmd=16'h4023, cmd_rdy=1, clr_cmd_rdy_UART pulses same cycle; resp=8'hA5.
- Single move: start_tour, move=8'h01 -> cmd=16'h4002 (N, 2 squares); after clr+send_resp -> cmd=16'h5BF1 (E, 1, fanfare); resp=8'h5A between legs.
- Move bit 3 -> 16'h47F1 then 16'h53F2. Move bit 6 -> 16'h47F1 then 16'h5BF2.
- Full tour: NUM_MOVES=24, respond to every leg -> mv_indx steps 0..23; 48 cmd_rdy assertions; final resp=8'hA5; back to IDLE and UART pass-through restored.
- Abort/robustness: sync reset mid-HORZ -> next cycle cmd_rdy=0, mv_indx=0, IDLE. start_tour during VERT_WT -> no effect. move=8'h00 -> IDLE, no cmd_rdy.
- Macro off (TOUR_CMD_FANFARE_EN undefined): move=8'h01 -> second leg 16'h4BF1.
